// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding,
// the MARCO request sequence and the POLO reply sequence.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int MARCO_LEN = 6;
  localparam logic [47:0] MARCO_SEQ = 48'h4D_41_52_43_4F_0A;
  localparam logic [7:0] MARCO_FIRST = 8'h4D;

  localparam int POLO_LEN = 5;
  localparam logic [39:0] POLO_SEQ = 40'h50_4F_4C_4F_0A;

  function automatic logic [7:0] marco_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = MARCO_SEQ[47:40];
      3'd1:    b = MARCO_SEQ[39:32];
      3'd2:    b = MARCO_SEQ[31:24];
      3'd3:    b = MARCO_SEQ[23:16];
      3'd4:    b = MARCO_SEQ[15:8];
      3'd5:    b = MARCO_SEQ[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_rx_marco_matcher.sv
// marco_matcher: tracks received bytes against "MARCO\n".
// Ports: clk, rst, rx_data/rx_valid/frame_err in; marco_hit out.
module marco_matcher
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_err,
  output logic       marco_hit
);

  logic [2:0] r_idx;
  logic       r_hit;
  logic [7:0] w_exp;

  assign w_exp     = marco_byte(r_idx);
  assign marco_hit = r_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 3'd0;
      r_hit <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (frame_err) begin
        r_idx <= 3'd0;
      end else if (rx_valid) begin
        if (rx_data == w_exp) begin
          if (r_idx == 3'(MARCO_LEN - 1)) begin
            r_hit <= 1'b1;
            r_idx <= 3'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end else begin
          // A stray 'M' may itself begin a new sequence.
          r_idx <= (rx_data == MARCO_FIRST) ? 3'd1 : 3'd0;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_marco.sv
// 8N1 UART receiver with "MARCO\n" detector.
// Ports: clk, rst, sample_tick, rx in; rx_data, rx_valid,
// frame_err, marco_hit, busy out.
module uart_rx_marco
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       marco_hit,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);

  logic            r_rx_meta;
  logic            r_rx_s;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_frame_err;
  logic            w_full;
  logic            w_half;

  assign w_full    = (r_cnt == CNT_FULL);
  assign w_half    = (r_cnt == CNT_HALF);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (sample_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_rx_s) begin
              r_cnt   <= '0;
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (w_half) begin
              // Line back high at mid start bit: noise.
              r_cnt     <= '0;
              r_bit_idx <= 3'd0;
              r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (w_full) begin
              r_cnt   <= '0;
              r_shift <= {r_rx_s, r_shift[7:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_full) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_state    <= ST_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_WAIT_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT_IDLE: begin
            // Hold off through a break so it reports once.
            if (r_rx_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  marco_matcher u_matcher (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (r_rx_data),
    .rx_valid  (r_rx_valid),
    .frame_err (r_frame_err),
    .marco_hit (marco_hit)
  );

endmodule

// File: tb/tb_uart_rx_marco.sv
// Directed bench for uart_rx_marco with byte scoreboard.
// Line is driven at 16 ticks/bit, one tick every 4 clks.
module tb_uart_rx_marco;

  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int BIT  = OS * TDIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       marco_hit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_hit   = 0;
  int tdiv    = 0;

  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx_marco #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .marco_hit   (marco_hit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv        = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
    sample_tick = (tdiv == 0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_valid || frame_err)
      chk("valid_ferr_excl", 32'(rx_valid & frame_err), 0);
    if (rx_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(rx_data), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(rx_data), 32'(e));
      end
    end
    if (frame_err) n_ferr++;
    if (marco_hit) begin
      n_hit++;
      chk("hit_after_0A", {23'd0, prev_valid, prev_data},
          {23'd0, 1'b1, 8'h0A});
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    if (stop) exp_q.push_back(b);
    rx = stop;
    wait_clks(BIT);
  endtask

  task automatic send_marco();
    send_byte(8'h4D, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h43, 1'b1);
    send_byte(8'h4F, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_rx_data"},   32'(rx_data),   0);
    chk({p, "_rx_valid"},  32'(rx_valid),  0);
    chk({p, "_frame_err"}, 32'(frame_err), 0);
    chk({p, "_marco_hit"}, 32'(marco_hit), 0);
    chk({p, "_busy"},      32'(busy),      0);
  endtask

  initial begin
    int v0, f0, h0;
    logic [7:0] b4d;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    chk_reset_outs("por");
    rst = 1'b0;
    wait_clks(BIT);

    // Clean 0x55
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h55, 1'b1);
    wait_clks(BIT);
    chk("t55_valids", n_valid - v0, 1);
    chk("t55_ferr",   n_ferr - f0,  0);
    chk("t55_data",   32'(rx_data), 32'h55);

    // 0.3-bit glitch
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    wait_clks(BIT * 3 / 10);
    chk("glitch_busy_hi", 32'(busy), 1);
    rx = 1'b1;
    wait_clks(BIT);
    chk("glitch_valids", n_valid - v0, 0);
    chk("glitch_ferr",   n_ferr - f0,  0);
    chk("glitch_busy_lo", 32'(busy), 0);

    // 0xA3 with low stop, then 3-bit break
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'hA3, 1'b0);
    wait_clks(3 * BIT);
    rx = 1'b1;
    wait_clks(2 * BIT);
    chk("brk_ferr",   n_ferr - f0,  1);
    chk("brk_valids", n_valid - v0, 0);
    chk("brk_data",   32'(rx_data), 32'h55);
    chk("brk_busy",   32'(busy),    0);

    // "MMARCO\n"
    v0 = n_valid; f0 = n_ferr; h0 = n_hit;
    send_byte(8'h4D, 1'b1);
    send_marco();
    wait_clks(2 * BIT);
    chk("mm_valids", n_valid - v0, 7);
    chk("mm_hits",   n_hit - h0,   1);
    chk("mm_ferr",   n_ferr - f0,  0);

    // "MAR" + framing error + "CO\n"
    v0 = n_valid; f0 = n_ferr; h0 = n_hit;
    send_byte(8'h4D, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h43, 1'b0);
    rx = 1'b1;
    wait_clks(BIT);
    send_byte(8'h43, 1'b1);
    send_byte(8'h4F, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_clks(2 * BIT);
    chk("fe_hits",   n_hit - h0,   0);
    chk("fe_ferr",   n_ferr - f0,  1);
    chk("fe_valids", n_valid - v0, 6);

    // Reset during bit 4 of 0x4D
    v0 = n_valid; f0 = n_ferr; h0 = n_hit;
    b4d = 8'h4D;
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b4d[i];
      wait_clks(BIT);
    end
    rx = b4d[4];
    wait_clks(BIT / 2);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    wait_clks(2);
    chk_reset_outs("mid");
    wait_clks(BIT / 2 - 2);
    for (int i = 5; i < 8; i++) begin
      rx = b4d[i];
      wait_clks(BIT);
    end
    rx = 1'b1;
    wait_clks(BIT / 2);
    chk_reset_outs("late");
    rst = 1'b0;
    wait_clks(BIT + BIT / 2);
    chk("rst_valids", n_valid - v0, 0);
    chk("rst_ferr",   n_ferr - f0,  0);
    chk("rst_busy",   32'(busy),    0);
    send_marco();
    wait_clks(2 * BIT);
    chk("post_hits",   n_hit - h0,   1);
    chk("post_valids", n_valid - v0, 6);
    chk("sb_empty",    exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_marco.md
UART_RX_MARCO -- requirements
Module: uart_rx_marco

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: sample ticks per bit period, even, minimum 8.
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sample_tick  input  1  one-clk pulse, OVERSAMPLE pulses per bit period (9600 baud x OVERSAMPLE).
REQ-005 SHALL have port rx  input  1  asynchronous UART line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte; held until the next valid byte.
REQ-007 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-008 SHALL have port frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-009 SHALL have port marco_hit  output  1  one-clk pulse when the sequence "MARCO\n" completes.
REQ-010 SHALL have port busy  output  1  high in every receiver state except IDLE.

Function
REQ-011 SHALL synchronise rx through two flops (initial value 1); all decisions use the synchronised value rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP, WAIT_IDLE; sample counter and bit index advance only on sample_tick cycles.
REQ-013 IDLE: on a sample_tick with rx_s==0, SHALL clear the sample counter and go to START.
REQ-014 START: after OVERSAMPLE/2 ticks (mid start bit), SHALL go to DATA if rx_s==0 (counter cleared); if rx_s==1 (glitch), SHALL return to IDLE with no output.
REQ-015 DATA: every OVERSAMPLE ticks, SHALL sample rx_s into the shift register LSB first; after bit index 7 is sampled, SHALL go to STOP.
REQ-016 STOP: after OVERSAMPLE ticks, if rx_s==1, SHALL load rx_data, pulse rx_valid on the next clk, and go to IDLE.
REQ-017 STOP: if rx_s==0, SHALL pulse frame_err, leave rx_data unchanged, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL stay until a sample_tick sees rx_s==1, then go to IDLE; a held-low break therefore produces exactly one frame_err.
REQ-019 Matcher SHALL hold index 0..5 over the expected bytes 0x4D 0x41 0x52 0x43 0x4F 0x0A and advance only on rx_valid.
REQ-020 Matcher: a byte equal to expected[index] SHALL increment the index; at index 5 it SHALL pulse marco_hit one clk after that rx_valid and return the index to 0.
REQ-021 Matcher: on a mismatching byte, SHALL set the index to 1 if the byte is 0x4D, otherwise 0.
REQ-022 Matcher: frame_err SHALL reset the index to 0.
REQ-023 End-to-end latency: rx_valid SHALL assert no later than 3 clks after the stop-bit sample tick (2 synchroniser + 1 register).
REQ-024 rx_valid and frame_err SHALL never assert in the same cycle.
REQ-025 marco_hit SHALL never assert without an rx_valid in the preceding cycle.

Reset
REQ-026 While rst is high: state=IDLE, counters=0, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, marco_hit=0, busy=0, synchroniser flops=1, matcher index=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulses; after release, the remainder of that frame SHALL produce no rx_valid unless a genuine start bit follows.

Structure
REQ-028 Shared package uart_pkg SHALL hold the receiver state enum, the MARCO byte constants, and the POLO constants shared with the transmitter.
REQ-029 The sequence matcher SHALL be a sub-module named marco_matcher (inputs rx_data, rx_valid, frame_err; output marco_hit).
REQ-030 The baud/oversample tick generator SHALL remain external to this block.

Verification
REQ-031 Bench: drive byte 0x55 with a correct stop bit -> one rx_valid, rx_data=0x55, frame_err never asserted.
REQ-032 Bench: drive a 0.3-bit-long low glitch -> no rx_valid, no frame_err, busy returns to 0.
REQ-033 Bench: drive byte 0xA3 with the stop bit low, then the line held low for 3 bit periods -> exactly one frame_err, rx_data keeps its prior value.
REQ-034 Bench: drive "MMARCO\n" back to back -> seven rx_valid pulses, exactly one marco_hit, one clk after the 0x0A rx_valid.
REQ-035 Bench: drive "MAR", then a framing-error byte, then "CO\n" -> no marco_hit.
REQ-036 Bench: assert rst during DATA bit 4 of 0x4D, release, then send "MARCO\n" -> all outputs at reset values during rst, then exactly one marco_hit.
